filter_frame_sequencer: RTL and testbench

//  Per-frame controller for the colour-detect bounding-box filter. Waits for a frame

---
 rtl/filter_frame_sequencer.sv | 127 ++++++++++++
 tb/tb_filter_frame_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_frame_sequencer.sv
// Per-frame controller for the colour-detect bounding-box filter: frame-sync start/ack
// handshake, stable box result registers, and filter recovery on timeout or error.
module filter_frame_sequencer #(
  parameter int TIMEOUT_CYCLES = 400000,
  parameter int RST_CYCLES     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        frame_sync,
  input  logic        clr_err,
  input  logic        flt_done,
  input  logic        flt_error,
  input  logic [8:0]  flt_x_min,
  input  logic [8:0]  flt_x_max,
  input  logic [8:0]  flt_y_min,
  input  logic [8:0]  flt_y_max,
  output logic        flt_start,
  output logic        flt_ack,
  output logic        filt_rst_n,
  output logic [8:0]  box_x_min,
  output logic [8:0]  box_x_max,
  output logic [8:0]  box_y_min,
  output logic [8:0]  box_y_max,
  output logic        box_valid,
  output logic        obj_found,
  output logic [15:0] frame_cnt,
  output logic [7:0]  overrun_cnt,
  output logic [7:0]  timeout_cnt,
  output logic        busy,
  output logic        fault
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] WAIT_SYNC = 3'd1;
  localparam logic [2:0] START     = 3'd2;
  localparam logic [2:0] BUSY      = 3'd3;
  localparam logic [2:0] ACK       = 3'd4;
  localparam logic [2:0] RECOVER   = 3'd5;
  localparam logic [2:0] FAULT     = 3'd6;

  localparam int         RW      = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [18:0] TO_LAST = 19'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);

  logic [2:0]    r_state;
  logic [2:0]    w_next;
  logic [18:0]   r_to_cnt;
  logic [RW-1:0] r_rst_cnt;
  logic          w_capture;
  logic          w_timeout;
  logic          w_overrun;
  logic [2:0]    w_resume;

  assign w_resume  = enable ? WAIT_SYNC : IDLE;
  // Error wins over done, and done wins over an expiring timeout.
  assign w_capture = (r_state == BUSY) && !flt_error && flt_done;
  assign w_timeout = (r_state == BUSY) && !flt_error && !flt_done && (r_to_cnt == TO_LAST);
  assign w_overrun = (r_state == BUSY) && frame_sync;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (enable) w_next = WAIT_SYNC;
      WAIT_SYNC: if (!enable) w_next = IDLE;
                 else if (frame_sync) w_next = START;
      START:     w_next = BUSY;
      BUSY:      if (flt_error) w_next = FAULT;
                 else if (flt_done) w_next = ACK;
                 else if (w_timeout) w_next = RECOVER;
      ACK:       if (!flt_done) w_next = w_resume;
      RECOVER:   if (r_rst_cnt == RST_LAST) w_next = w_resume;
      FAULT:     if (clr_err) w_next = RECOVER;
      default:   w_next = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_to_cnt   <= '0;
      r_rst_cnt  <= '0;
      flt_start  <= 1'b0;
      flt_ack    <= 1'b0;
      filt_rst_n <= 1'b1;
      busy       <= 1'b0;
      fault      <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_to_cnt   <= (r_state == BUSY) ? r_to_cnt + 19'd1 : '0;
      r_rst_cnt  <= (r_state == RECOVER) ? r_rst_cnt + RW'(1) : '0;
      flt_start  <= (w_next == START);
      flt_ack    <= (w_next == ACK);
      filt_rst_n <= !((w_next == RECOVER) || (w_next == FAULT));
      busy       <= (w_next == START) || (w_next == BUSY) || (w_next == ACK);
      fault      <= (w_next == FAULT);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      box_x_min   <= '0;
      box_x_max   <= '0;
      box_y_min   <= '0;
      box_y_max   <= '0;
      box_valid   <= 1'b0;
      obj_found   <= 1'b0;
      frame_cnt   <= '0;
      overrun_cnt <= '0;
      timeout_cnt <= '0;
    end else begin
      if (w_capture) begin
        box_x_min <= flt_x_min;
        box_x_max <= flt_x_max;
        box_y_min <= flt_y_min;
        box_y_max <= flt_y_max;
        box_valid <= 1'b1;
        obj_found <= (flt_x_min <= flt_x_max) && (flt_y_min <= flt_y_max);
        frame_cnt <= frame_cnt + 16'd1;
      end
      if (w_overrun && (overrun_cnt != 8'hFF)) overrun_cnt <= overrun_cnt + 8'd1;
      if (w_timeout && (timeout_cnt != 8'hFF)) timeout_cnt <= timeout_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_filter_frame_sequencer.sv
// Directed bench for filter_frame_sequencer: normal frame, empty box, timeout, fault,
// overrun with done/timeout race, reset and enable behaviour.
module tb_filter_frame_sequencer;
  logic        clk = 1'b0;
  logic        reset, enable, frame_sync, clr_err, flt_done, flt_error;
  logic [8:0]  flt_x_min, flt_x_max, flt_y_min, flt_y_max;
  logic        flt_start, flt_ack, filt_rst_n, box_valid, obj_found, busy, fault;
  logic [8:0]  box_x_min, box_x_max, box_y_min, box_y_max;
  logic [15:0] frame_cnt;
  logic [7:0]  overrun_cnt, timeout_cnt;

  int checks = 0;
  int failures = 0;

  filter_frame_sequencer #(.TIMEOUT_CYCLES(100), .RST_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .frame_sync(frame_sync), .clr_err(clr_err),
    .flt_done(flt_done), .flt_error(flt_error),
    .flt_x_min(flt_x_min), .flt_x_max(flt_x_max), .flt_y_min(flt_y_min), .flt_y_max(flt_y_max),
    .flt_start(flt_start), .flt_ack(flt_ack), .filt_rst_n(filt_rst_n),
    .box_x_min(box_x_min), .box_x_max(box_x_max), .box_y_min(box_y_min), .box_y_max(box_y_max),
    .box_valid(box_valid), .obj_found(obj_found), .frame_cnt(frame_cnt),
    .overrun_cnt(overrun_cnt), .timeout_cnt(timeout_cnt), .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse frame_sync in WAIT_SYNC; returns flt_start one cycle later, ends in first BUSY cycle.
  task automatic start_frame(output logic st);
    frame_sync = 1'b1;
    tick();
    st = flt_start;
    frame_sync = 1'b0;
    tick();
  endtask

  task automatic set_box(input int a, input int b, input int c, input int d);
    flt_x_min = 9'(a); flt_x_max = 9'(b); flt_y_min = 9'(c); flt_y_max = 9'(d);
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 0; frame_sync = 0; clr_err = 0; flt_done = 0; flt_error = 0;
    set_box(0, 0, 0, 0);
    repeat (3) tick();
    checks++;
    if ({flt_start, flt_ack, filt_rst_n, box_valid, obj_found, busy, fault} !== 7'b0010000 ||
        frame_cnt !== 16'd0 || overrun_cnt !== 8'd0 || timeout_cnt !== 8'd0 || box_x_min !== 9'd0) begin
      failures++;
      $display("FAIL reset_state: ctl=%b frame_cnt=%0d expected ctl=0010000 counts 0",
               {flt_start, flt_ack, filt_rst_n, box_valid, obj_found, busy, fault}, frame_cnt);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_normal_frame();
    logic st;
    enable = 1'b1;
    tick();
    start_frame(st);
    checks++;
    if (st !== 1'b1) begin failures++; $display("FAIL start_latency: flt_start=%b expected 1", st); end
    checks++;
    if (flt_start !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL start_one_cycle: flt_start=%b busy=%b expected 0/1", flt_start, busy);
    end
    repeat (48) tick();
    checks++;
    if (box_valid !== 1'b0) begin failures++; $display("FAIL valid_before_done: got %b expected 0", box_valid); end
    set_box(30, 150, 30, 150);
    flt_done = 1'b1;
    tick();
    checks++;
    if (box_x_min !== 9'd30 || box_x_max !== 9'd150 || box_y_min !== 9'd30 || box_y_max !== 9'd150) begin
      failures++;
      $display("FAIL box_capture: got (%0d,%0d,%0d,%0d) expected (30,150,30,150)",
               box_x_min, box_x_max, box_y_min, box_y_max);
    end
    checks++;
    if (box_valid !== 1'b1 || obj_found !== 1'b1 || frame_cnt !== 16'd1 || flt_ack !== 1'b1) begin
      failures++;
      $display("FAIL frame_flags: valid=%b found=%b cnt=%0d ack=%b expected 1 1 1 1",
               box_valid, obj_found, frame_cnt, flt_ack);
    end
    set_box(7, 8, 9, 10);
    repeat (3) tick();
    checks++;
    if (flt_ack !== 1'b1 || box_x_min !== 9'd30) begin
      failures++; $display("FAIL ack_hold: ack=%b x_min=%0d expected 1 30", flt_ack, box_x_min);
    end
    flt_done = 1'b0;
    tick();
    checks++;
    if (flt_ack !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL ack_release: ack=%b busy=%b expected 0 0", flt_ack, busy);
    end
  endtask

  task automatic test_empty_box();
    logic st;
    start_frame(st);
    repeat (5) tick();
    set_box(319, 0, 10, 20);
    flt_done = 1'b1;
    tick();
    flt_done = 1'b0;
    checks++;
    if (obj_found !== 1'b0 || box_valid !== 1'b1 || box_x_min !== 9'd319 || box_x_max !== 9'd0 ||
        box_y_min !== 9'd10 || box_y_max !== 9'd20) begin
      failures++;
      $display("FAIL empty_box: found=%b valid=%b box=(%0d,%0d,%0d,%0d) expected 0 1 (319,0,10,20)",
               obj_found, box_valid, box_x_min, box_x_max, box_y_min, box_y_max);
    end
    tick();
  endtask

  task automatic test_timeout();
    logic st;
    int n, low;
    start_frame(st);
    n = 0;
    while (filt_rst_n && n < 200) begin tick(); n++; end
    checks++;
    if (n !== 100) begin failures++; $display("FAIL timeout_cycles: got %0d expected 100", n); end
    checks++;
    if (timeout_cnt !== 8'd1) begin failures++; $display("FAIL timeout_cnt: got %0d expected 1", timeout_cnt); end
    low = 0;
    while (!filt_rst_n && low < 50) begin tick(); low++; end
    checks++;
    if (low !== 4) begin failures++; $display("FAIL recover_len: got %0d expected 4", low); end
    checks++;
    if (box_x_min !== 9'd319 || box_valid !== 1'b1 || frame_cnt !== 16'd2 || busy !== 1'b0) begin
      failures++;
      $display("FAIL timeout_box_kept: x_min=%0d valid=%b cnt=%0d busy=%b expected 319 1 2 0",
               box_x_min, box_valid, frame_cnt, busy);
    end
  endtask

  task automatic test_fault();
    logic st;
    int bad, low;
    start_frame(st);
    repeat (3) tick();
    flt_error = 1'b1;
    tick();
    flt_error = 1'b0;
    checks++;
    if (fault !== 1'b1 || filt_rst_n !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL fault_entry: fault=%b rst_n=%b busy=%b expected 1 0 0", fault, filt_rst_n, busy);
    end
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      frame_sync = (i % 50) == 7;
      enable = !(i >= 300 && i < 600);
      tick();
      if (!(fault && !filt_rst_n && !flt_start)) bad++;
    end
    frame_sync = 1'b0;
    enable = 1'b1;
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL fault_hold: %0d bad cycles, expected 0", bad); end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    checks++;
    if (fault !== 1'b0) begin failures++; $display("FAIL clr_err: fault=%b expected 0", fault); end
    low = 0;
    while (!filt_rst_n && low < 50) begin low++; tick(); end
    checks++;
    if (low !== 4) begin failures++; $display("FAIL fault_recover_len: got %0d expected 4", low); end
    start_frame(st);
    checks++;
    if (st !== 1'b1 || timeout_cnt !== 8'd1) begin
      failures++; $display("FAIL after_fault: start=%b timeout_cnt=%0d expected 1 1", st, timeout_cnt);
    end
    set_box(1, 2, 3, 4);
    flt_done = 1'b1;
    tick();
    flt_done = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic st;
    int starts;
    start_frame(st);
    starts = st ? 1 : 0;
    set_box(5, 100, 6, 200);
    for (int i = 0; i < 100; i++) begin
      frame_sync = (i == 10) || (i == 20) || (i == 30);
      flt_done = (i == 99);
      tick();
      if (flt_start) starts++;
    end
    frame_sync = 1'b0;
    checks++;
    if (overrun_cnt !== 8'd3 || starts !== 1) begin
      failures++; $display("FAIL overrun: cnt=%0d starts=%0d expected 3 1", overrun_cnt, starts);
    end
    checks++;
    if (flt_ack !== 1'b1 || filt_rst_n !== 1'b1 || timeout_cnt !== 8'd1 || frame_cnt !== 16'd4 ||
        box_x_max !== 9'd100 || obj_found !== 1'b1) begin
      failures++;
      $display("FAIL done_at_timeout: ack=%b rst_n=%b to=%0d cnt=%0d x_max=%0d expected 1 1 1 4 100",
               flt_ack, filt_rst_n, timeout_cnt, frame_cnt, box_x_max);
    end
    flt_done = 1'b0;
    tick();
  endtask

  task automatic test_reset_and_enable();
    logic st;
    start_frame(st);
    repeat (5) tick();
    reset = 1'b1;
    #1;
    checks++;
    if ({flt_start, flt_ack, filt_rst_n, box_valid, obj_found, busy, fault} !== 7'b0010000 ||
        frame_cnt !== 16'd0 || overrun_cnt !== 8'd0 || timeout_cnt !== 8'd0 || box_x_max !== 9'd0) begin
      failures++;
      $display("FAIL reset_midframe: ctl=%b cnt=%0d ovr=%0d to=%0d expected ctl=0010000 counts 0",
               {flt_start, flt_ack, filt_rst_n, box_valid, obj_found, busy, fault},
               frame_cnt, overrun_cnt, timeout_cnt);
    end
    tick();
    reset = 1'b0;
    tick();
    start_frame(st);
    enable = 1'b0;
    repeat (3) tick();
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL enable_drop_busy: busy=%b expected 1", busy); end
    set_box(11, 12, 13, 14);
    flt_done = 1'b1;
    tick();
    flt_done = 1'b0;
    checks++;
    if (frame_cnt !== 16'd1 || box_y_max !== 9'd14) begin
      failures++; $display("FAIL enable_drop_done: cnt=%0d y_max=%0d expected 1 14", frame_cnt, box_y_max);
    end
    tick();
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || flt_start !== 1'b0) begin
      failures++; $display("FAIL idle_after_drop: busy=%b start=%b expected 0 0", busy, flt_start);
    end
  endtask

  initial begin
    test_reset();
    test_normal_frame();
    test_empty_box();
    test_timeout();
    test_fault();
    test_back_to_back();
    test_reset_and_enable();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
